// File: rtl/icache_fill_controller_if.sv
// ---------------------------------------------------------------------------
// icache_fill_controller_if
//
// Bundles every handshake and bus signal around the instruction-cache fill
// controller: the fetch-request port, the flush strobe, the CacheMemory
// fetch and update ports, and the memory line-read port.  Signal names keep
// their controller-relative direction suffix (_i into the controller, _o out
// of it) so waveforms read the same on both sides.
//
// Modports
//   master : the fill controller itself
//   slave  : the surroundings (fetch unit, CacheMemory, memory bus, bench)
//
// Address and line vectors use ascending [0:N-1] numbering: bit 0 is the
// most significant bit, so {tag, index, offset} packs straight into an
// address and beat 0 lands in the top 64 bits of the line.
// ---------------------------------------------------------------------------
interface icache_fill_controller_if #(
  parameter int TAG_W    = 51,
  parameter int INDEX_W  = 8,
  parameter int OFFSET_W = 5,
  parameter int LINE_W   = 256,
  parameter int BEAT_W   = 64
);
  localparam int ADDR_W = TAG_W + INDEX_W + OFFSET_W;

  // fetch request
  logic                  reqValid_i;
  logic [0:ADDR_W-1]     reqAddr_i;
  logic                  reqReady_o;
  logic                  flush_i;

  // CacheMemory fetch port
  logic                  fetchEnable_o;
  logic [TAG_W-1:0]      tag_o;
  logic [INDEX_W-1:0]    index_o;
  logic [OFFSET_W-1:0]   offset_o;

  // CacheMemory update port
  logic                  updateEnable_o;
  logic [0:LINE_W-1]     newCacheline_o;
  logic [INDEX_W-1:0]    newIndex_o;

  // memory line-read port
  logic                  memReqValid_o;
  logic [0:ADDR_W-1]     memReqAddr_o;
  logic                  memReqReady_i;
  logic                  memRespValid_i;
  logic [0:BEAT_W-1]     memRespData_i;

  // status
  logic                  miss_o;

  modport master (
    input  reqValid_i, reqAddr_i, flush_i,
    input  memReqReady_i, memRespValid_i, memRespData_i,
    output reqReady_o,
    output fetchEnable_o, tag_o, index_o, offset_o,
    output updateEnable_o, newCacheline_o, newIndex_o,
    output memReqValid_o, memReqAddr_o,
    output miss_o
  );

  modport slave (
    output reqValid_i, reqAddr_i, flush_i,
    output memReqReady_i, memRespValid_i, memRespData_i,
    input  reqReady_o,
    input  fetchEnable_o, tag_o, index_o, offset_o,
    input  updateEnable_o, newCacheline_o, newIndex_o,
    input  memReqValid_o, memReqAddr_o,
    input  miss_o
  );
endinterface

// File: rtl/icache_fill_controller.sv
// ---------------------------------------------------------------------------
// icache_fill_controller
//
// Sequencer in front of a direct-mapped instruction-cache data array
// (256 lines x 256 bits).  It owns the tag and valid arrays, classifies each
// accepted fetch request as hit or miss, turns hits into a CacheMemory fetch
// on the next cycle, and on a miss reads the line from memory in four 64-bit
// beats, writes it into CacheMemory, and then replays the fetch.  Fetch and
// update strobes to CacheMemory are never asserted in the same cycle.
//
// Ports
//   clock_i  : single clock, rising edge
//   reset_i  : asynchronous, active-low reset
//   fill_if  : master side of icache_fill_controller_if
//              reqValid_i/reqAddr_i/reqReady_o  fetch request handshake
//              flush_i                          invalidate the whole cache
//              fetchEnable_o/tag_o/index_o/offset_o   CacheMemory fetch
//              updateEnable_o/newCacheline_o/newIndex_o CacheMemory write
//              memReqValid_o/memReqAddr_o/memReqReady_i line read request
//              memRespValid_i/memRespData_i     returned beats
//              miss_o                           high while a miss is serviced
//
// State table
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   S_IDLE   | accept requests, look up tags, execute flushes
//   S_MREQ   | line read request held on the memory bus until accepted
//   S_FILL   | collecting four beats into the line buffer
//   S_UPDATE | one-cycle CacheMemory write; tag/valid updated on its edge
//   S_REPLAY | one-cycle CacheMemory fetch for the request that missed
// ---------------------------------------------------------------------------
module icache_fill_controller #(
  parameter int TAG_W    = 51,
  parameter int INDEX_W  = 8,
  parameter int OFFSET_W = 5,
  parameter int LINE_W   = 256,
  parameter int BEAT_W   = 64
) (
  input  logic                      clock_i,
  input  logic                      reset_i,
  icache_fill_controller_if.master  fill_if
);

  localparam int ADDR_W    = TAG_W + INDEX_W + OFFSET_W;
  localparam int NUM_LINES = 1 << INDEX_W;
  localparam int BEATS     = LINE_W / BEAT_W;
  localparam int BEAT_CW   = $clog2(BEATS);
  localparam logic [BEAT_CW-1:0] LAST_BEAT = BEAT_CW'(BEATS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MREQ,
    S_FILL,
    S_UPDATE,
    S_REPLAY
  } state_t;

  state_t                 state_q;
  logic                   flush_pend_q;
  logic [BEAT_CW-1:0]     beat_q;
  logic [NUM_LINES-1:0]   valid_q;
  logic [TAG_W-1:0]       tag_arr_q [NUM_LINES];

  // registered outputs; tag_q/index_q/offset_q also hold the request that
  // is being serviced across a miss
  logic                   fetch_en_q;
  logic [TAG_W-1:0]       tag_q;
  logic [INDEX_W-1:0]     index_q;
  logic [OFFSET_W-1:0]    offset_q;
  logic                   update_en_q;
  logic [0:LINE_W-1]      line_q;
  logic [INDEX_W-1:0]     new_index_q;
  logic                   mem_req_valid_q;
  logic [0:ADDR_W-1]      mem_req_addr_q;
  logic                   miss_q;

  // incoming request fields and lookup
  logic [TAG_W-1:0]       req_tag;
  logic [INDEX_W-1:0]     req_index;
  logic [OFFSET_W-1:0]    req_offset;
  logic                   req_hit;
  logic                   flush_now;

  assign req_tag    = fill_if.reqAddr_i[0 : TAG_W-1];
  assign req_index  = fill_if.reqAddr_i[TAG_W : TAG_W+INDEX_W-1];
  assign req_offset = fill_if.reqAddr_i[TAG_W+INDEX_W : ADDR_W-1];
  assign req_hit    = valid_q[req_index] && (tag_arr_q[req_index] == req_tag);

  // a deferred flush runs on the first IDLE cycle exactly like a live one
  assign flush_now  = fill_if.flush_i || flush_pend_q;

  assign fill_if.reqReady_o = (state_q == S_IDLE) && !fill_if.flush_i && !flush_pend_q;

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q         <= S_IDLE;
      flush_pend_q    <= 1'b0;
      beat_q          <= '0;
      valid_q         <= '0;
      fetch_en_q      <= 1'b0;
      tag_q           <= '0;
      index_q         <= '0;
      offset_q        <= '0;
      update_en_q     <= 1'b0;
      line_q          <= '0;
      new_index_q     <= '0;
      mem_req_valid_q <= 1'b0;
      mem_req_addr_q  <= '0;
      miss_q          <= 1'b0;
    end else begin
      // both CacheMemory strobes are single-cycle pulses
      fetch_en_q  <= 1'b0;
      update_en_q <= 1'b0;

      // flushes arriving mid-refill are remembered until IDLE
      if (state_q != S_IDLE && fill_if.flush_i) begin
        flush_pend_q <= 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (flush_now) begin
            valid_q      <= '0;
            flush_pend_q <= 1'b0;
          end else if (fill_if.reqValid_i) begin
            tag_q    <= req_tag;
            index_q  <= req_index;
            offset_q <= req_offset;
            if (req_hit) begin
              fetch_en_q <= 1'b1;
            end else begin
              mem_req_valid_q <= 1'b1;
              mem_req_addr_q  <= {req_tag, req_index, {OFFSET_W{1'b0}}};
              miss_q          <= 1'b1;
              state_q         <= S_MREQ;
            end
          end
        end

        S_MREQ: begin
          if (fill_if.memReqReady_i) begin
            mem_req_valid_q <= 1'b0;
            beat_q          <= '0;
            state_q         <= S_FILL;
          end
        end

        S_FILL: begin
          if (fill_if.memRespValid_i) begin
            line_q[int'(beat_q) * BEAT_W +: BEAT_W] <= fill_if.memRespData_i;
            beat_q <= beat_q + 1'b1;
            if (beat_q == LAST_BEAT) begin
              update_en_q <= 1'b1;
              new_index_q <= index_q;
              state_q     <= S_UPDATE;
            end
          end
        end

        S_UPDATE: begin
          valid_q[index_q] <= 1'b1;
          fetch_en_q       <= 1'b1;
          state_q          <= S_REPLAY;
        end

        S_REPLAY: begin
          miss_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Tag storage is deliberately not reset; valid_q alone qualifies it.
  // A reset during a refill forces state_q back to IDLE, so no tag write
  // can follow an abandoned fill.
  always_ff @(posedge clock_i) begin
    if (state_q == S_UPDATE) begin
      tag_arr_q[index_q] <= tag_q;
    end
  end

  assign fill_if.fetchEnable_o  = fetch_en_q;
  assign fill_if.tag_o          = tag_q;
  assign fill_if.index_o        = index_q;
  assign fill_if.offset_o       = offset_q;
  assign fill_if.updateEnable_o = update_en_q;
  assign fill_if.newCacheline_o = line_q;
  assign fill_if.newIndex_o     = new_index_q;
  assign fill_if.memReqValid_o  = mem_req_valid_q;
  assign fill_if.memReqAddr_o   = mem_req_addr_q;
  assign fill_if.miss_o         = miss_q;

endmodule

// File: tb/tb_icache_fill_controller.sv
// ---------------------------------------------------------------------------
// tb_icache_fill_controller
//
// Directed bench for icache_fill_controller.  Inputs change and outputs are
// sampled on the falling clock edge; the design acts on rising edges.
// ---------------------------------------------------------------------------
module tb_icache_fill_controller;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_bad;
  logic mon_on;

  icache_fill_controller_if fill_if ();

  icache_fill_controller dut (
    .clock_i (clk),
    .reset_i (rst_n),
    .fill_if (fill_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // CacheMemory must never see fetch and update together
  always @(negedge clk) begin
    if (mon_on && rst_n) begin
      chk("fetch_update_excl", 256'(fill_if.fetchEnable_o & fill_if.updateEnable_o), 256'd0);
    end
  end

  task automatic do_hits(input logic [50:0] t, input logic [7:0] ix,
                         input logic [4:0] of0, input logic [4:0] of1);
    fill_if.reqValid_i = 1'b1;
    fill_if.reqAddr_i  = {t, ix, of0};
    chk("hit_ready0", 256'(fill_if.reqReady_o), 256'd1);
    @(negedge clk);
    chk("hit_fetch0", 256'(fill_if.fetchEnable_o), 256'd1);
    chk("hit_tag0", 256'(fill_if.tag_o), 256'(t));
    chk("hit_index0", 256'(fill_if.index_o), 256'(ix));
    chk("hit_offset0", 256'(fill_if.offset_o), 256'(of0));
    chk("hit_memreq0", 256'(fill_if.memReqValid_o), 256'd0);
    chk("hit_ready1", 256'(fill_if.reqReady_o), 256'd1);
    fill_if.reqAddr_i = {t, ix, of1};
    @(negedge clk);
    fill_if.reqValid_i = 1'b0;
    chk("hit_fetch1", 256'(fill_if.fetchEnable_o), 256'd1);
    chk("hit_offset1", 256'(fill_if.offset_o), 256'(of1));
    chk("hit_memreq1", 256'(fill_if.memReqValid_o), 256'd0);
    chk("hit_miss1", 256'(fill_if.miss_o), 256'd0);
    @(negedge clk);
    chk("hit_fetch_off", 256'(fill_if.fetchEnable_o), 256'd0);
  endtask

  // Full miss: request, optional memReqReady stall, four back-to-back beats,
  // update, replay.  fl_beat >= 0 pulses flush_i alongside that beat.
  task automatic req_miss(input logic [50:0] t, input logic [7:0] ix, input logic [4:0] of,
                          input logic [63:0] b0, input logic [63:0] b1,
                          input logic [63:0] b2, input logic [63:0] b3,
                          input int stall, input int fl_beat);
    logic [63:0]  beats [4];
    logic [63:0]  exp_addr;
    logic [255:0] exp_line;
    beats    = '{b0, b1, b2, b3};
    exp_addr = {t, ix, 5'd0};
    exp_line = {b0, b1, b2, b3};

    chk("acc_ready", 256'(fill_if.reqReady_o), 256'd1);
    fill_if.reqValid_i = 1'b1;
    fill_if.reqAddr_i  = {t, ix, of};
    @(negedge clk);
    fill_if.reqValid_i = 1'b0;
    fill_if.reqAddr_i  = '1;
    chk("mreq_valid", 256'(fill_if.memReqValid_o), 256'd1);
    chk("mreq_addr", 256'(fill_if.memReqAddr_o), 256'(exp_addr));
    chk("mreq_miss", 256'(fill_if.miss_o), 256'd1);
    chk("mreq_ready_low", 256'(fill_if.reqReady_o), 256'd0);
    chk("mreq_fetch", 256'(fill_if.fetchEnable_o), 256'd0);
    for (int s = 0; s < stall; s++) begin
      fill_if.memReqReady_i = 1'b0;
      @(negedge clk);
      chk("stall_valid", 256'(fill_if.memReqValid_o), 256'd1);
      chk("stall_addr", 256'(fill_if.memReqAddr_o), 256'(exp_addr));
    end
    fill_if.memReqReady_i = 1'b1;
    @(negedge clk);
    fill_if.memReqReady_i = 1'b0;
    chk("fill_mreq_low", 256'(fill_if.memReqValid_o), 256'd0);
    for (int k = 0; k < 4; k++) begin
      fill_if.memRespValid_i = 1'b1;
      fill_if.memRespData_i  = beats[k];
      fill_if.flush_i        = (k == fl_beat);
      chk("fill_update_low", 256'(fill_if.updateEnable_o), 256'd0);
      chk("fill_miss", 256'(fill_if.miss_o), 256'd1);
      @(negedge clk);
    end
    fill_if.memRespValid_i = 1'b0;
    fill_if.memRespData_i  = 64'h0123_4567_89ab_cdef;
    fill_if.flush_i        = 1'b0;
    chk("upd_enable", 256'(fill_if.updateEnable_o), 256'd1);
    chk("upd_index", 256'(fill_if.newIndex_o), 256'(ix));
    chk("upd_line", 256'(fill_if.newCacheline_o), exp_line);
    chk("upd_fetch", 256'(fill_if.fetchEnable_o), 256'd0);
    @(negedge clk);
    chk("rep_fetch", 256'(fill_if.fetchEnable_o), 256'd1);
    chk("rep_update", 256'(fill_if.updateEnable_o), 256'd0);
    chk("rep_tag", 256'(fill_if.tag_o), 256'(t));
    chk("rep_index", 256'(fill_if.index_o), 256'(ix));
    chk("rep_offset", 256'(fill_if.offset_o), 256'(of));
    chk("rep_miss", 256'(fill_if.miss_o), 256'd1);
    chk("rep_ready", 256'(fill_if.reqReady_o), 256'd0);
    @(negedge clk);
    chk("idle_miss", 256'(fill_if.miss_o), 256'd0);
    chk("idle_fetch", 256'(fill_if.fetchEnable_o), 256'd0);
    chk("idle_ready", 256'(fill_if.reqReady_o), 256'(fl_beat < 0));
    if (fl_beat >= 0) begin
      @(negedge clk);
      chk("post_flush_ready", 256'(fill_if.reqReady_o), 256'd1);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_fetch"}, 256'(fill_if.fetchEnable_o), 256'd0);
    chk({tag, "_update"}, 256'(fill_if.updateEnable_o), 256'd0);
    chk({tag, "_memreq"}, 256'(fill_if.memReqValid_o), 256'd0);
    chk({tag, "_miss"}, 256'(fill_if.miss_o), 256'd0);
    chk({tag, "_tag"}, 256'(fill_if.tag_o), 256'd0);
    chk({tag, "_index"}, 256'(fill_if.index_o), 256'd0);
    chk({tag, "_offset"}, 256'(fill_if.offset_o), 256'd0);
    chk({tag, "_newindex"}, 256'(fill_if.newIndex_o), 256'd0);
    chk({tag, "_line"}, 256'(fill_if.newCacheline_o), 256'd0);
    chk({tag, "_memaddr"}, 256'(fill_if.memReqAddr_o), 256'd0);
    chk({tag, "_ready"}, 256'(fill_if.reqReady_o), 256'd1);
  endtask

  localparam logic [63:0] A0 = 64'hFFFFFFFF_EEEEEEEE;
  localparam logic [63:0] A1 = 64'hDDDDDDDD_CCCCCCCC;
  localparam logic [63:0] A2 = 64'hBBBBBBBB_AAAAAAAA;
  localparam logic [63:0] A3 = 64'h99999999_88888888;

  initial begin
    n_chk  = 0;
    n_bad  = 0;
    mon_on = 1'b0;
    rst_n  = 1'b0;
    fill_if.reqValid_i     = 1'b0;
    fill_if.reqAddr_i      = '0;
    fill_if.flush_i        = 1'b0;
    fill_if.memReqReady_i  = 1'b0;
    fill_if.memRespValid_i = 1'b0;
    fill_if.memRespData_i  = '0;

    // reset state
    repeat (2) @(negedge clk);
    chk_all_zero("rst");
    fill_if.flush_i = 1'b1;
    #1;
    chk("rst_flush_ready", 256'(fill_if.reqReady_o), 256'd0);
    fill_if.flush_i = 1'b0;
    @(negedge clk);
    rst_n  = 1'b1;
    mon_on = 1'b1;
    @(negedge clk);

    // cold miss
    req_miss(51'd55, 8'd0, 5'd7, A0, A1, A2, A3, 0, -1);

    // back-to-back hits; stray beats in IDLE must not touch the line buffer
    fill_if.memRespValid_i = 1'b1;
    fill_if.memRespData_i  = 64'hDEAD_BEEF_DEAD_BEEF;
    do_hits(51'd55, 8'd0, 5'd7, 5'd3);
    fill_if.memRespValid_i = 1'b0;
    chk("stray_beat_ignored", 256'(fill_if.newCacheline_o), {A0, A1, A2, A3});

    // conflict on index 0
    req_miss(51'd123, 8'd0, 5'd5, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888,
             64'h9999_AAAA_BBBB_CCCC, 64'hDDDD_EEEE_FFFF_0000, 0, -1);
    do_hits(51'd123, 8'd0, 5'd0, 5'd31);
    req_miss(51'd55, 8'd0, 5'd7, A0, A1, A2, A3, 0, -1);

    // memory request backpressure, then hit on a far index
    req_miss(51'h7_FFFF_FFFF_FFFF, 8'd255, 5'd31, 64'h0, 64'h1, 64'h2, 64'h3, 3, -1);
    do_hits(51'h7_FFFF_FFFF_FFFF, 8'd255, 5'd31, 5'd1);

    // flush during fill: the fresh line and the older ones all go away
    req_miss(51'd9, 8'd1, 5'd2, 64'hA5A5_A5A5_A5A5_A5A5, 64'h5A5A_5A5A_5A5A_5A5A,
             64'h0F0F_0F0F_0F0F_0F0F, 64'hF0F0_F0F0_F0F0_F0F0, 0, 1);
    req_miss(51'd9, 8'd1, 5'd2, 64'h1, 64'h2, 64'h3, 64'h4, 0, -1);
    req_miss(51'd55, 8'd0, 5'd7, A0, A1, A2, A3, 0, -1);

    // reset after two beats of a refill
    fill_if.reqValid_i = 1'b1;
    fill_if.reqAddr_i  = {51'd200, 8'd3, 5'd1};
    @(negedge clk);
    fill_if.reqValid_i    = 1'b0;
    fill_if.memReqReady_i = 1'b1;
    @(negedge clk);
    fill_if.memReqReady_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      fill_if.memRespValid_i = 1'b1;
      fill_if.memRespData_i  = 64'hCAFE_0000_0000_0000 | 64'(k);
      @(negedge clk);
    end
    fill_if.memRespValid_i = 1'b0;
    mon_on = 1'b0;
    rst_n  = 1'b0;
    #1;
    chk_all_zero("midrst");
    @(negedge clk);
    chk_all_zero("midrst_hold");
    rst_n  = 1'b1;
    mon_on = 1'b1;
    @(negedge clk);
    req_miss(51'd200, 8'd3, 5'd1, 64'hAAAA, 64'hBBBB, 64'hCCCC, 64'hDDDD, 0, -1);
    // index 0 was valid before the reset; it must have been invalidated
    req_miss(51'd55, 8'd0, 5'd7, A0, A1, A2, A3, 1, -1);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/icache_fill_controller.md
# icache_fill_controller

Sequencer for the direct-mapped instruction cache data array (256 lines × 256 bits), placed between the fetch unit, CacheMemory and the memory bus. Holds the tag and valid arrays and classifies each fetch request as a hit or a miss. A hit becomes a CacheMemory fetch. A miss fetches the line from memory in 64-bit beats, writes it into CacheMemory, and then replays the fetch. The block guarantees that CacheMemory never sees fetch and update in the same cycle.

## Interface
- TAG_W, 51, tag width (address bits 0:50)
- INDEX_W, 8, index width (address bits 51:58)
- OFFSET_W, 5, byte offset within the line (address bits 59:63)
- LINE_W, 256, cache line width
- BEAT_W, 64, memory beat width; BEATS = LINE_W/BEAT_W = 4

Ports:
- clock_i  in  1  single clock, rising edge
- reset_i  in  1  asynchronous, active-low reset
- reqValid_i  in  1  fetch request valid
- reqAddr_i  in  64  fetch address, [0:63] big-endian bit order
- reqReady_o  out  1  request accepted on the cycle where reqValid_i && reqReady_o
- flush_i  in  1  invalidate the whole cache
- fetchEnable_o  out  1  CacheMemory fetch strobe
- tag_o / index_o / offset_o  out  51/8/5  CacheMemory fetch fields
- updateEnable_o  out  1  CacheMemory write strobe
- newCacheline_o  out  256  assembled line
- newIndex_o  out  8  line write index
- memReqValid_o  out  1  line read request
- memReqAddr_o  out  64  line-aligned address (offset bits = 0)
- memReqReady_i  in  1  memory accepts the request
- memRespValid_i  in  1  beat valid
- memRespData_i  in  64  beat data; beat k fills newCacheline_o[64k:64k+63]
- miss_o  out  1  high while a miss is being serviced (states MREQ through REPLAY)

## Operation
- State machine: IDLE, MREQ, FILL, UPDATE, REPLAY.
- **IDLE**
  - reqReady_o = (state==IDLE) && !flush_i && !flushPending. This is combinational.
  - On acceptance, the controller registers the address and looks up valid[index] && tagArray[index]==tag.
  - Hit: fetchEnable_o=1 next cycle with the registered tag/index/offset; state stays IDLE.
  - Miss: go to MREQ.
- **MREQ**
  - memReqValid_o=1 with memReqAddr_o = {tag, index, 5'b0}, held stable until memReqReady_i.
  - On handshake: go to FILL with beat counter = 0.
- **FILL**
  - Each memRespValid_i stores memRespData_i into slot [counter] and increments the 2-bit counter.
  - On the 4th beat: go to UPDATE.
  - memRespValid_i outside FILL is ignored.
- **UPDATE**
  - One cycle with updateEnable_o=1, newIndex_o=index, newCacheline_o=assembled line.
  - On the same edge: tagArray[index]=tag and valid[index]=1. A valid line at that index is overwritten.
- **REPLAY**
  - One cycle with fetchEnable_o=1 for the held request; then go to IDLE.
- **Flush**
  - In IDLE, flush_i clears all 256 valid bits at the next edge and has priority over request acceptance.
  - Outside IDLE, flush_i sets flushPending. The flush executes on the first IDLE cycle and also invalidates the line just filled. flushPending clears when it executes.
- fetchEnable_o and updateEnable_o are mutually exclusive in every cycle.
- Tag and valid arrays are plain registers; valid[] is reset, tagArray[] is not.

## Timing
- **Reset** (reset_i low, asynchronous):
  - State = IDLE; all valid bits = 0; flushPending = 0; counter = 0.
  - All registered outputs = 0: fetchEnable_o, updateEnable_o, memReqValid_o, miss_o, tag_o, index_o, offset_o, newIndex_o, newCacheline_o, memReqAddr_o.
  - reqReady_o = 1 whenever flush_i is low.
- **Reset during MREQ/FILL/UPDATE:** the refill is abandoned and no tag or valid bit is written. The memory side is reset by the same reset_i.
- **Hit latency:** accepted at edge N; fetchEnable_o is high for cycle N+1; reqReady_o stays high, so back-to-back hits sustain 1 per cycle.
- **Miss latency** with memReqReady_i=1 and beats on consecutive cycles:
  - Accept at edge N.
  - memReqValid_o in cycle N+1.
  - Beats in cycles N+2..N+5.
  - updateEnable_o in cycle N+6.
  - fetchEnable_o in cycle N+7.
  - reqReady_o high again in cycle N+8.
- **Stalls:** memReqReady_i low stretches MREQ; gaps in memRespValid_i stretch FILL. The FSM waits without limit, with no timeout.

## Test plan
1. **Cold miss:** reset, then request tag 55, index 0, offset 7.
   - memReqAddr_o has tag 55, index 0, offset 0.
   - Beats FFFFFFFF_EEEEEEEE, DDDDDDDD_CCCCCCCC, BBBBBBBB_AAAAAAAA, 99999999_88888888 → updateEnable_o with newIndex_o=0 and newCacheline_o = FFFFFFFF_EEEEEEEE_…_88888888.
   - Next cycle: fetchEnable_o with tag_o=55, offset_o=7.
2. **Hit:** repeat tag 55/index 0, then tag 55/index 0/offset 3 back-to-back → fetchEnable_o on two consecutive cycles; memReqValid_o stays 0.
3. **Conflict:** tag 123, index 0 → miss and refill, then the tag 55/index 0 request misses again.
4. **Request backpressure:** memReqReady_i low 3 cycles → memReqValid_o held 4 cycles with memReqAddr_o stable, then normal fill.
5. **Flush:**
   - Pulse flush_i during FILL of index 1, tag 9 → after REPLAY, reqReady_o is low for one IDLE cycle.
   - Request tag 9/index 1 → miss.
   - Check fetchEnable_o and updateEnable_o are never both 1.
6. **Reset mid-fill:** assert reset_i after 2 beats → all outputs 0; the same request afterwards misses and refetches 4 beats.
